// File: rtl/axi_rd_burst_ctrl.sv
// AXI4 read-master that splits (address, word count) commands into INCR bursts
// capped at MAX_BURST_LEN beats and never crossing 4 KB, streaming data out with a command-level last.
module axi_rd_burst_ctrl #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 16,
   parameter int ID_WIDTH      = 8,
   parameter int AXI_ID        = 0,
   parameter int MAX_BURST_LEN = 16,
   parameter int LEN_WIDTH     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int SIZE  = $clog2(BYTES);
   localparam int CW    = ((LEN_WIDTH > 13) ? LEN_WIDTH : 13) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

   state_t                r_state;
   state_t                w_state_nx;
   logic [ADDR_WIDTH-1:0] r_cur_addr;
   logic [LEN_WIDTH-1:0]  r_remaining;
   logic [7:0]            r_beat_cnt;
   logic                  r_err;
   logic [CW-1:0]         w_to_4k;
   logic [CW-1:0]         w_lim;
   logic [CW-1:0]         w_blen;
   logic                  w_beat;
   logic                  w_last_beat;
   logic                  w_unused;

   // rid carries no information with a single burst in flight
   assign w_unused = ^m_axi_rid;

   if (ADDR_WIDTH >= 12) begin : g_4k
      assign w_to_4k = CW'((13'h1000 - {1'b0, r_cur_addr[11:0]}) >> SIZE);
   end else begin : g_no4k
      assign w_to_4k = CW'(MAX_BURST_LEN);
   end

   always_comb begin
      w_lim = CW'(MAX_BURST_LEN);
      if (w_to_4k < w_lim) w_lim = w_to_4k;
      w_blen = CW'(r_remaining);
      if (w_lim < w_blen) w_blen = w_lim;
   end

   assign w_beat      = (r_state == S_DATA) && m_axi_rvalid && m_ready;
   assign w_last_beat = (r_beat_cnt == 8'd0);

   assign m_axi_arid    = ID_WIDTH'(AXI_ID);
   assign m_axi_araddr  = r_cur_addr;
   assign m_axi_arsize  = 3'(SIZE);
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arprot  = 3'b000;
   assign m_data        = m_axi_rdata;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx    = r_state;
      cmd_ready     = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_arlen   = 8'd0;
      m_axi_rready  = 1'b0;
      m_valid       = 1'b0;
      m_last        = 1'b0;
      done          = 1'b0;
      err           = 1'b0;
      busy          = 1'b1;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) w_state_nx = (cmd_len == '0) ? S_DONE : S_ADDR;
         end
         S_ADDR: begin
            m_axi_arvalid = 1'b1;
            m_axi_arlen   = 8'(w_blen - CW'(1));
            if (m_axi_arready) w_state_nx = S_DATA;
         end
         S_DATA: begin
            m_valid      = m_axi_rvalid;
            m_axi_rready = m_ready;
            m_last       = m_axi_rvalid && w_last_beat && (r_remaining == '0);
            if (w_beat && w_last_beat) w_state_nx = (r_remaining != '0) ? S_ADDR : S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            err        = r_err;
            w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Burst bookkeeping; rlast is only cross-checked, the beat counter sequences
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cur_addr  <= '0;
         r_remaining <= '0;
         r_beat_cnt  <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_cur_addr  <= cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
                  r_remaining <= cmd_len;
                  r_err       <= 1'b0;
               end
            end
            S_ADDR: begin
               if (m_axi_arready) begin
                  r_cur_addr  <= r_cur_addr + (ADDR_WIDTH'(w_blen) << SIZE);
                  r_remaining <= r_remaining - LEN_WIDTH'(w_blen);
                  r_beat_cnt  <= 8'(w_blen - CW'(1));
               end
            end
            S_DATA: begin
               if (w_beat) begin
                  r_beat_cnt <= r_beat_cnt - 8'd1;
                  if ((m_axi_rresp != 2'b00) || (m_axi_rlast != w_last_beat)) r_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
